// File: rtl/dht11_sensor_emulator_pkg.sv
// Shared definitions for the DHT11 responder: FSM states, fixed protocol
// durations and the frame builder used when the host release is accepted.
package dht11_sensor_emulator_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HOST_LOW,
    RESP_DELAY,
    PRES_LOW,
    PRES_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW,
    COOLDOWN
  } state_t;

  localparam int PRES_LOW_US  = 80;
  localparam int PRES_HIGH_US = 80;
  localparam int BIT_LOW_US   = 50;
  localparam int END_LOW_US   = 50;
  localparam int FRAME_BITS   = 40;

  // Checksum is the byte sum truncated to 8 bits, optionally inverted.
  function automatic logic [39:0] build_frame(input logic [7:0] hum_int,
                                              input logic [7:0] hum_dec,
                                              input logic [7:0] temp_int,
                                              input logic [7:0] temp_dec,
                                              input logic       invert);
    logic [7:0] ck;
    ck = hum_int + hum_dec + temp_int + temp_dec;
    if (invert) ck = ~ck;
    return {hum_int, hum_dec, temp_int, temp_dec, ck};
  endfunction

endpackage

// File: rtl/dht11_sensor_emulator_if.sv
// Control and status bundle between a host-side controller and the DHT11 responder.
interface dht11_sensor_emulator_if;
  logic       enable;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       force_cksum_error;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, hum_int, hum_dec, temp_int, temp_dec, force_cksum_error,
    input  busy, frame_done
  );

  modport slave (
    input  enable, hum_int, hum_dec, temp_int, temp_dec, force_cksum_error,
    output busy, frame_done
  );
endinterface

// File: rtl/dht11_sensor_emulator_us_tick.sv
// Free-running microsecond timebase: tick is high for one clock every CYCLES_PER_US cycles.
module dht11_us_tick #(
  parameter int CYCLES_PER_US = 50
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int            CW   = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_US - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 responder: detects the host start pulse, answers with the presence
// pulse and shifts out a 40-bit frame on an open-drain single-wire line.
module dht11_sensor_emulator
  import dht11_sensor_emulator_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int BIT1_HIGH_US  = 70,
  parameter int BIT0_HIGH_US  = 26,
  parameter int COOLDOWN_US   = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  dht11_sensor_emulator_if.slave  bus,
  inout  wire                     transmission_line
);
  localparam int         CYCLES_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam logic [5:0] LAST_BIT      = 6'(FRAME_BITS - 1);

  state_t        state, state_next;
  logic          us_tick;
  logic          line_meta, line_sync;
  logic [15:0]   timer;
  logic [15:0]   phase_len;
  logic          phase_done;
  logic [5:0]    bit_idx;
  logic [39:0]   frame;
  logic          bit_val;
  logic          snapshot;
  logic          advance_bit;
  logic          frame_done_pulse;
  logic          drive_low;

  dht11_us_tick #(.CYCLES_PER_US(CYCLES_PER_US)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (us_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Line synchronizer idles high so reset never looks like a start pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
      timer     <= '0;
      bit_idx   <= '0;
      frame     <= '0;
    end else begin
      line_meta <= transmission_line;
      line_sync <= line_meta;
      if (state_next != state)        timer <= '0;
      else if (us_tick && timer != '1) timer <= timer + 16'd1;
      if (snapshot) begin
        frame   <= build_frame(bus.hum_int, bus.hum_dec, bus.temp_int,
                               bus.temp_dec, bus.force_cksum_error);
        bit_idx <= '0;
      end else if (advance_bit) begin
        bit_idx <= bit_idx + 6'd1;
      end
    end
  end

  assign bit_val = frame[LAST_BIT - bit_idx];

  always_comb begin
    phase_len = 16'd1;
    case (state)
      RESP_DELAY: phase_len = 16'(RESP_DELAY_US);
      PRES_LOW:   phase_len = 16'(PRES_LOW_US);
      PRES_HIGH:  phase_len = 16'(PRES_HIGH_US);
      BIT_LOW:    phase_len = 16'(BIT_LOW_US);
      BIT_HIGH:   phase_len = bit_val ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      END_LOW:    phase_len = 16'(END_LOW_US);
      COOLDOWN:   phase_len = 16'(COOLDOWN_US);
      default:    phase_len = 16'd1;
    endcase
  end

  assign phase_done = us_tick && (timer == phase_len - 16'd1);

  always_comb begin
    state_next       = state;
    snapshot         = 1'b0;
    advance_bit      = 1'b0;
    frame_done_pulse = 1'b0;
    case (state)
      IDLE:       if (!line_sync) state_next = HOST_LOW;
      HOST_LOW: begin
        if (line_sync) begin
          if (timer >= 16'(START_MIN_US)) begin
            state_next = RESP_DELAY;
            snapshot   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      RESP_DELAY: if (phase_done) state_next = PRES_LOW;
      PRES_LOW:   if (phase_done) state_next = PRES_HIGH;
      PRES_HIGH:  if (phase_done) state_next = BIT_LOW;
      BIT_LOW:    if (phase_done) state_next = BIT_HIGH;
      BIT_HIGH: begin
        if (phase_done) begin
          if (bit_idx == LAST_BIT) begin
            state_next = END_LOW;
          end else begin
            state_next  = BIT_LOW;
            advance_bit = 1'b1;
          end
        end
      end
      END_LOW: begin
        if (phase_done) begin
          state_next       = COOLDOWN;
          frame_done_pulse = 1'b1;
        end
      end
      COOLDOWN:   if (phase_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    // Disabling aborts any frame silently.
    if (!bus.enable) begin
      state_next       = IDLE;
      snapshot         = 1'b0;
      advance_bit      = 1'b0;
      frame_done_pulse = 1'b0;
    end
  end

  assign drive_low = (state == PRES_LOW) || (state == BIT_LOW) || (state == END_LOW);
  assign transmission_line = drive_low ? 1'b0 : 1'bz;

  assign bus.busy       = (state != IDLE) && (state != HOST_LOW);
  assign bus.frame_done = frame_done_pulse;
endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Directed bench for the DHT11 responder: acts as the host, decodes pulse widths
// into a frame and compares against hand-computed frames.
module tb_dht11_sensor_emulator;
  localparam int CLK_FREQ_HZ   = 2_000_000;
  localparam int START_MIN_US  = 180;
  localparam int COOLDOWN_US   = 100;
  localparam int MEASURE_LIMIT = 1000;
  localparam int START_CYCLES  = 440;
  localparam int SHORT_CYCLES  = 200;

  logic clock = 1'b0;
  logic reset;
  logic host_low;
  wire  transmission_line;

  int vectors          = 0;
  int miscompares      = 0;
  int frame_done_count = 0;

  dht11_sensor_emulator_if bus ();

  assign transmission_line = host_low ? 1'b0 : 1'bz;
  pullup (transmission_line);

  dht11_sensor_emulator #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .START_MIN_US  (START_MIN_US),
    .RESP_DELAY_US (30),
    .BIT1_HIGH_US  (70),
    .BIT0_HIGH_US  (26),
    .COOLDOWN_US   (COOLDOWN_US)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .transmission_line (transmission_line)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.frame_done === 1'b1) frame_done_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] hd,
                               input logic [7:0] ti, input logic [7:0] td,
                               input logic force_err);
    bus.hum_int           = hi;
    bus.hum_dec           = hd;
    bus.temp_int          = ti;
    bus.temp_dec          = td;
    bus.force_cksum_error = force_err;
  endtask

  task automatic host_start(input int low_cycles);
    @(negedge clock);
    host_low = 1'b1;
    repeat (low_cycles) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (transmission_line === lvl && len < MEASURE_LIMIT) begin
      @(negedge clock);
      len++;
    end
  endtask

  task automatic wait_falls(input int n, input int limit, output bit timed_out);
    logic prev;
    int   falls;
    int   waited;
    prev   = 1'b1;
    falls  = 0;
    waited = 0;
    while (falls < n && waited < limit) begin
      @(negedge clock);
      waited++;
      if (prev === 1'b1 && transmission_line === 1'b0) falls++;
      prev = transmission_line;
    end
    timed_out = (falls < n);
  endtask

  // Pulse widths are counted in clocks (2 per us); highs of 48us or more decode as '1'.
  task automatic read_frame(output logic [39:0] data, output int pres_low,
                            output int pres_high, output int bit_low,
                            output int end_low, output bit timed_out);
    int waited;
    int low_len;
    int high_len;
    data      = '0;
    pres_low  = 0;
    pres_high = 0;
    bit_low   = 0;
    end_low   = 0;
    timed_out = 1'b0;
    waited    = 0;
    @(negedge clock);
    while (transmission_line !== 1'b0 && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 400) begin
      timed_out = 1'b1;
      return;
    end
    measure(1'b0, pres_low);
    measure(1'b1, pres_high);
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, low_len);
      measure(1'b1, high_len);
      if (i == 0) bit_low = low_len;
      if (low_len >= MEASURE_LIMIT || high_len >= MEASURE_LIMIT) timed_out = 1'b1;
      data = {data[38:0], (high_len >= 96)};
    end
    measure(1'b0, end_low);
    if (pres_low >= MEASURE_LIMIT || pres_high >= MEASURE_LIMIT || end_low >= MEASURE_LIMIT)
      timed_out = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [39:0] exp_frame,
                             input int fd_before, input logic [39:0] data,
                             input int pl, input int ph, input int bl, input int el,
                             input bit timed_out);
    checkOutput({name, "_timeout"},      64'(timed_out), 64'd0);
    checkOutput({name, "_pres_low_us"},  64'((pl + 1) / 2), 64'd80);
    checkOutput({name, "_pres_high_us"}, 64'((ph + 1) / 2), 64'd80);
    checkOutput({name, "_bit_low_us"},   64'((bl + 1) / 2), 64'd50);
    checkOutput({name, "_end_low_us"},   64'((el + 1) / 2), 64'd50);
    checkOutput({name, "_frame"},        64'(data), 64'(exp_frame));
    checkOutput({name, "_busy_cool"},    64'(bus.busy), 64'd1);
    checkOutput({name, "_done_once"},    64'(frame_done_count - fd_before), 64'd1);
    repeat (COOLDOWN_US * 2 + 10) @(negedge clock);
    checkOutput({name, "_busy_after"},   64'(bus.busy), 64'd0);
    checkOutput({name, "_line_after"},   64'(transmission_line), 64'd1);
  endtask

  task automatic run_frame(input string name, input logic [39:0] exp_frame);
    logic [39:0] data;
    int pl, ph, bl, el, fd_before;
    bit timed_out;
    fd_before = frame_done_count;
    host_start(START_CYCLES);
    read_frame(data, pl, ph, bl, el, timed_out);
    check_frame(name, exp_frame, fd_before, data, pl, ph, bl, el, timed_out);
  endtask

  initial begin
    logic [39:0] data;
    int  pl, ph, bl, el, fd_before;
    bit  timed_out, saw_low, saw_busy;

    reset      = 1'b1;
    host_low   = 1'b0;
    bus.enable = 1'b1;
    applyStimulus(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("reset_line", 64'(transmission_line), 64'd1);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.frame_done), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    $display("[TB] test 1: normal frame");
    run_frame("t1", 40'h3700190050);

    $display("[TB] test 2: short start pulse");
    fd_before = frame_done_count;
    host_start(SHORT_CYCLES);
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (transmission_line === 1'b0) saw_low = 1'b1;
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    checkOutput("t2_line_low", 64'(saw_low), 64'd0);
    checkOutput("t2_busy", 64'(saw_busy), 64'd0);
    checkOutput("t2_done", 64'(frame_done_count - fd_before), 64'd0);

    $display("[TB] test 3: forced checksum error");
    applyStimulus(8'h37, 8'h00, 8'h19, 8'h00, 1'b1);
    run_frame("t3", 40'h37001900AF);
    applyStimulus(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);

    $display("[TB] test 4: disable during bit 12");
    fd_before = frame_done_count;
    host_start(START_CYCLES);
    wait_falls(14, 5000, timed_out);
    checkOutput("t4_falls_timeout", 64'(timed_out), 64'd0);
    bus.enable = 1'b0;
    @(negedge clock);
    checkOutput("t4_line_released", 64'(transmission_line), 64'd1);
    checkOutput("t4_busy", 64'(bus.busy), 64'd0);
    saw_low = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (transmission_line === 1'b0) saw_low = 1'b1;
    end
    checkOutput("t4_line_low", 64'(saw_low), 64'd0);
    checkOutput("t4_done", 64'(frame_done_count - fd_before), 64'd0);
    bus.enable = 1'b1;
    repeat (5) @(negedge clock);
    run_frame("t4_retry", 40'h3700190050);

    $display("[TB] test 5: bytes change mid-frame");
    fd_before = frame_done_count;
    fork
      begin
        host_start(START_CYCLES);
        read_frame(data, pl, ph, bl, el, timed_out);
      end
      begin
        bit falls_to;
        wait_falls(7, 5000, falls_to);
        checkOutput("t5_falls_timeout", 64'(falls_to), 64'd0);
        bus.hum_int = 8'h50;
      end
    join
    check_frame("t5", 40'h3700190050, fd_before, data, pl, ph, bl, el, timed_out);
    run_frame("t5_next", 40'h5000190069);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
